float_triple_stream_sorter: RTL

- Sequential front-end for three-float sorting.
- Accepts FP64 values one at a time over a valid/ready stream and collects them into a triple.
- Sorts the triple in increasing order over three cycles, reusing a single f_less_or_equal instance.
- Presents the sorted triple plus an error flag on a valid/ready output.
- Sits between a scalar float producer and any consumer of sorted triples; it is the area-saving, time-multiplexed alternative to a fully combinational three-comparator sorter.

---
 rtl/float_triple_stream_sorter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/float_triple_stream_sorter.sv
// Collects three FP64 values from a stream, sorts them ascending over three
// cycles with one shared comparator, and presents the sorted triple.
//
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   up_valid/up_ready   input stream handshake
//   up_data             one unsorted float
//   down_valid/ready    output stream handshake
//   down_sorted         sorted triple, [0] is the smallest
//   down_err            a compare on this triple reported err

module float_triple_stream_sorter (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 up_valid,
  input  logic [63:0]          up_data,
  output logic                 up_ready,
  output logic                 down_valid,
  input  logic                 down_ready,
  output logic [0:2][63:0]     down_sorted,
  output logic                 down_err
);

  localparam int FLEN = 64;

  typedef enum logic [2:0] {
    S_COLLECT,
    S_CMP_A,
    S_CMP_B,
    S_CMP_C,
    S_OUT
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [1:0]            r_cnt;
  logic [0:2][FLEN-1:0]  r_buf;
  logic                  r_err;
  logic [FLEN-1:0]       w_a;
  logic [FLEN-1:0]       w_b;
  logic                  w_res;
  logic                  w_cmp_err;
  logic                  w_in_xfer;

  assign w_in_xfer = up_valid & up_ready;

  // CMP_B works on the upper pair; CMP_A and CMP_C on the lower pair.
  always_comb begin
    w_a = r_buf[0];
    w_b = r_buf[1];
    if (r_state == S_CMP_B) begin
      w_a = r_buf[1];
      w_b = r_buf[2];
    end
  end

  f_less_or_equal u_cmp (
    .a   (w_a),
    .b   (w_b),
    .res (w_res),
    .err (w_cmp_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_COLLECT: begin
        if (w_in_xfer && r_cnt == 2'd2) begin
          w_next = S_CMP_A;
        end
      end
      S_CMP_A: w_next = S_CMP_B;
      S_CMP_B: w_next = S_CMP_C;
      S_CMP_C: w_next = S_OUT;
      S_OUT: begin
        if (down_ready) begin
          w_next = S_COLLECT;
        end
      end
      default: w_next = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 2'd0;
      r_buf <= '0;
      r_err <= 1'b0;
    end else begin
      unique case (r_state)
        S_COLLECT: begin
          if (w_in_xfer) begin
            case (r_cnt)
              2'd0:    r_buf[0] <= up_data;
              2'd1:    r_buf[1] <= up_data;
              default: r_buf[2] <= up_data;
            endcase
            r_cnt <= (r_cnt == 2'd2) ? 2'd0 : r_cnt + 2'd1;
          end
        end
        S_CMP_A, S_CMP_C: begin
          // Equal values give res=1, so they keep their order.
          if (!w_res) begin
            r_buf[0] <= r_buf[1];
            r_buf[1] <= r_buf[0];
          end
          r_err <= r_err | w_cmp_err;
        end
        S_CMP_B: begin
          if (!w_res) begin
            r_buf[1] <= r_buf[2];
            r_buf[2] <= r_buf[1];
          end
          r_err <= r_err | w_cmp_err;
        end
        S_OUT: begin
          if (down_ready) begin
            r_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign up_ready    = (r_state == S_COLLECT) & ~rst;
  assign down_valid  = (r_state == S_OUT);
  assign down_err    = down_valid & r_err;
  assign down_sorted = r_buf;

endmodule

// IEEE-754 binary64 a <= b. Any NaN operand gives res=0 and err=1.
// +0 and -0 compare equal.
module f_less_or_equal (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        res,
  output logic        err
);

  logic w_nan_a;
  logic w_nan_b;
  logic w_zero;

  assign w_nan_a = (&a[62:52]) & (|a[51:0]);
  assign w_nan_b = (&b[62:52]) & (|b[51:0]);
  assign w_zero  = ~(|a[62:0]) & ~(|b[62:0]);

  always_comb begin
    res = 1'b0;
    err = 1'b0;
    if (w_nan_a || w_nan_b) begin
      err = 1'b1;
    end else if (w_zero) begin
      res = 1'b1;
    end else if (a[63] != b[63]) begin
      res = a[63];
    end else if (!a[63]) begin
      res = (a[62:0] <= b[62:0]);
    end else begin
      res = (a[62:0] >= b[62:0]);
    end
  end

endmodule
